// File: rtl/vpe_relu_writeback.sv
// ReLU + FIFO + row-coalescing writeback stage feeding the VPE register file.
// Optional perf counters enabled by defining VPE_WB_PERF_EN.
module vpe_relu_writeback #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned FLUSH_TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  i_data,
   input  logic         i_data_v,
   input  logic         i_en_relu,
   input  logic [4:0]   i_rf_idx,
   input  logic [1:0]   i_rf_mux,
   output logic         o_rf_wr_en,
   output logic [4:0]   o_rf_wr_addr,
   output logic [255:0] o_rf_wr_data,
   output logic [3:0]   o_rf_wr_be,
   input  logic         i_rf_wr_rdy,
   output logic         o_ovf,
   output logic         o_busy
`ifdef VPE_WB_PERF_EN
   ,
   output logic [15:0]  o_perf_wr_cnt,
   output logic [15:0]  o_perf_drop_cnt
`endif
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam int unsigned EW = 71;

   typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

   // Stage R
   logic [63:0] relu_data;
   logic        r_v_q;
   logic [63:0] r_data_q;
   logic [4:0]  r_idx_q;
   logic [1:0]  r_mux_q;

   always_comb begin
      relu_data = i_data;
      for (int b = 0; b < 8; b++) begin
         if (i_en_relu && i_data[8*b+7]) relu_data[8*b +: 8] = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v_q    <= 1'b0;
         r_data_q <= '0;
         r_idx_q  <= '0;
         r_mux_q  <= '0;
      end else begin
         r_v_q    <= i_data_v;
         r_data_q <= relu_data;
         r_idx_q  <= i_rf_idx;
         r_mux_q  <= i_rf_mux;
      end
   end

   // FIFO
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          fifo_full, fifo_empty, pop, push_ok, drop;
   logic [EW-1:0] head;
   logic [4:0]    head_idx;
   logic [1:0]    head_mux;
   logic [63:0]   head_data;
   logic          ovf_q;

   assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign push_ok    = r_v_q && (!fifo_full || pop);
   assign drop       = r_v_q && fifo_full && !pop;
   assign head       = mem_q[rd_ptr_q];
   assign head_idx   = head[70:66];
   assign head_mux   = head[65:64];
   assign head_data  = head[63:0];

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {r_idx_q, r_mux_q, r_data_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
         if (drop) ovf_q <= 1'b1;
      end
   end

   // Row coalescing FSM
   state_e         state_q, state_d;
   logic [255:0]   row_data_q, row_data_d;
   logic [3:0]     be_q, be_d;
   logic [4:0]     row_idx_q, row_idx_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           merge, wr_fire;

   always_comb begin
      state_d    = state_q;
      row_data_d = row_data_q;
      be_d       = be_q;
      row_idx_d  = row_idx_q;
      timer_d    = timer_q;
      pop        = 1'b0;
      merge      = 1'b0;
      wr_fire    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               merge     = 1'b1;
               row_idx_d = head_idx;
               timer_d   = '0;
               state_d   = StCollect;
            end
         end
         StCollect: begin
            if (be_q == 4'hF) begin
               state_d = StWrite;
            end else if (!fifo_empty) begin
               if (head_idx == row_idx_q && !be_q[head_mux]) begin
                  pop     = 1'b1;
                  merge   = 1'b1;
                  timer_d = '0;
               end else begin
                  state_d = StWrite;
               end
            end else if (timer_q == TW'(FLUSH_TIMEOUT - 1)) begin
               state_d = StWrite;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWrite: begin
            if (i_rf_wr_rdy) begin
               wr_fire    = 1'b1;
               be_d       = '0;
               row_data_d = '0;
               timer_d    = '0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (merge) begin
         be_d[head_mux] = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (head_mux == 2'(k)) row_data_d[64*k +: 64] = head_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         row_data_q <= '0;
         be_q       <= '0;
         row_idx_q  <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         row_data_q <= row_data_d;
         be_q       <= be_d;
         row_idx_q  <= row_idx_d;
         timer_q    <= timer_d;
      end
   end

   // Request fields are only exposed while a write is pending
   assign o_rf_wr_en   = (state_q == StWrite);
   assign o_rf_wr_addr = o_rf_wr_en ? row_idx_q  : '0;
   assign o_rf_wr_data = o_rf_wr_en ? row_data_q : '0;
   assign o_rf_wr_be   = o_rf_wr_en ? be_q       : '0;
   assign o_ovf        = ovf_q;
   assign o_busy       = r_v_q || !fifo_empty || (state_q != StIdle);

`ifdef VPE_WB_PERF_EN
   logic [15:0] perf_wr_q, perf_drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_wr_q   <= '0;
         perf_drop_q <= '0;
      end else begin
         if (wr_fire && perf_wr_q != 16'hFFFF)  perf_wr_q   <= perf_wr_q + 1'b1;
         if (drop && perf_drop_q != 16'hFFFF)   perf_drop_q <= perf_drop_q + 1'b1;
      end
   end

   assign o_perf_wr_cnt   = perf_wr_q;
   assign o_perf_drop_cnt = perf_drop_q;
`else
   logic unused_wr_fire;
   assign unused_wr_fire = wr_fire;
`endif

endmodule
